tx_pkt_loader: RTL and testbench

Store-and-forward packet loader that sits directly upstream of the MAC transmit encapsulator's TX FIFO. It accepts 64-bit host packet words with start/end markers and byte enables, buffers a whole frame, and measures its length. It pads runts to the minimum frame size and drops oversize or aborted frames. It then writes one length header word followed by the data words into the TX FIFO, in the format the encapsulator consumes.

---
 rtl/tx_pkt_loader_pkg.sv | 35 +++
 rtl/tx_pkt_loader_buf.sv | 23 ++
 rtl/tx_pkt_loader.sv | 147 ++++++++++++++
 tb/tb_tx_pkt_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkt_loader_pkg.sv
// Shared definitions for the TX packet loader and the encapsulator it feeds:
// state encodings, header layout and the frame size defaults.
package tx_pkt_loader_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_FILL  = 5'b00010,
      ST_DROP  = 5'b00100,
      ST_HDR   = 5'b01000,
      ST_DRAIN = 5'b10000
   } state_t;

   localparam int DEF_MIN_BYTES = 60;
   localparam int DEF_MAX_BYTES = 1518;
   localparam int HDR_LEN_W     = 16;

   function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
      return n;
   endfunction

   function automatic logic [63:0] keep_mask(input logic [7:0] keep);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{keep[i]}};
      return m;
   endfunction

   // Length lives in the low bits of the header word, the rest is reserved zero.
   function automatic logic [63:0] make_hdr(input logic [HDR_LEN_W-1:0] len);
      return {{(64-HDR_LEN_W){1'b0}}, len};
   endfunction

endpackage

// File: rtl/tx_pkt_loader_buf.sv
// Frame buffer: simple dual-port RAM with registered read. A read of the
// address being written in the same cycle returns the new data.
module tx_pkt_buf #(
   parameter int AW = 8,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
   end

endmodule

// File: rtl/tx_pkt_loader.sv
// Store-and-forward loader: buffers a host frame, pads runts, drops oversize
// or aborted frames, then writes a length header plus data into the TX FIFO.
module tx_pkt_loader
   import tx_pkt_loader_pkg::*;
#(
   parameter int BUF_AW    = 8,
   parameter int MAX_BYTES = DEF_MAX_BYTES,
   parameter int MIN_BYTES = DEF_MIN_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [7:0]  in_keep,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic        txfifo_full,
   output logic        txfifo_wr_en,
   output logic [63:0] txfifo_din,
   output logic [31:0] pkt_cnt,
   output logic [15:0] drop_cnt,
   output logic        err_oversize
);

   localparam int CW = BUF_AW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(2**BUF_AW);

   state_t        state;
   logic [15:0]   byte_cnt;
   logic [CW-1:0] word_cnt, nwords_q, rd_idx, wr_left;
   logic          out_valid, rd_pad;
   logic [63:0]   ram_q;

   logic          acc, restart, frame_word, oversize, go_hdr, wr, adv, rd_en, buf_we;
   logic [15:0]   base_bytes, new_bytes, len;
   logic [CW-1:0] base_words, new_words, tot_words;
   logic [BUF_AW-1:0] rd_addr;
   logic [63:0]   wr_data, next_word;

   // Input handshake: a word moves when in_valid & in_ready in the same cycle;
   // FIFO handshake: a word moves when txfifo_wr_en, which is never high with txfifo_full.
   always_comb begin
      acc        = in_valid && in_ready;
      restart    = acc && in_sop;
      frame_word = restart || (acc && state == ST_FILL);
      base_bytes = restart ? 16'd0 : byte_cnt;
      base_words = restart ? '0 : word_cnt;
      new_bytes  = base_bytes + (in_eop ? {12'd0, keep_bytes(in_keep)} : 16'd8);
      new_words  = base_words + CW'(1);
      oversize   = frame_word && (new_bytes > 16'(MAX_BYTES) || base_words == DEPTH);
      go_hdr     = frame_word && in_eop && !oversize;
      len        = (new_bytes < 16'(MIN_BYTES)) ? 16'(MIN_BYTES) : new_bytes;
      tot_words  = CW'((len + 16'd7) >> 3);
      buf_we     = frame_word && !oversize;
      wr_data    = in_eop ? (in_data & keep_mask(in_keep)) : in_data;
      wr         = out_valid && !txfifo_full;
      adv        = wr && (state == ST_HDR || (state == ST_DRAIN && wr_left != CW'(1)));
      rd_en      = go_hdr || adv;
      rd_addr    = go_hdr ? '0 : rd_idx[BUF_AW-1:0];
      next_word  = rd_pad ? 64'd0 : ram_q;
   end

   assign txfifo_wr_en = wr;

   tx_pkt_buf #(.AW(BUF_AW), .DW(64)) u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (base_words[BUF_AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         in_ready     <= 1'b0;
         byte_cnt     <= '0;
         word_cnt     <= '0;
         nwords_q     <= '0;
         rd_idx       <= '0;
         wr_left      <= '0;
         out_valid    <= 1'b0;
         rd_pad       <= 1'b1;
         txfifo_din   <= '0;
         pkt_cnt      <= '0;
         drop_cnt     <= '0;
         err_oversize <= 1'b0;
      end else begin
         err_oversize <= oversize;
         if ((restart && state == ST_FILL) || oversize)
            drop_cnt <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
         if (frame_word) begin
            byte_cnt <= new_bytes;
            word_cnt <= new_words;
         end
         // The RAM output register is the prefetch stage; it only advances when
         // the output register takes its word, so stalls never skip or repeat.
         if (rd_en) begin
            rd_pad <= go_hdr ? 1'b0 : (rd_idx >= nwords_q);
            rd_idx <= go_hdr ? CW'(1) : rd_idx + CW'(1);
         end
         case (state)
            ST_IDLE, ST_FILL, ST_DROP: begin
               in_ready <= !go_hdr;
               if (oversize) begin
                  state <= in_eop ? ST_IDLE : ST_DROP;
               end else if (go_hdr) begin
                  state      <= ST_HDR;
                  nwords_q   <= new_words;
                  wr_left    <= tot_words;
                  out_valid  <= 1'b1;
                  txfifo_din <= make_hdr(len);
               end else if (frame_word) begin
                  state <= ST_FILL;
               end else if (acc && in_eop) begin
                  state <= ST_IDLE;
               end
            end
            ST_HDR: begin
               if (wr) begin
                  txfifo_din <= next_word;
                  state      <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (wr) begin
                  if (wr_left == CW'(1)) begin
                     out_valid  <= 1'b0;
                     txfifo_din <= '0;
                     pkt_cnt    <= pkt_cnt + 32'd1;
                     in_ready   <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     txfifo_din <= next_word;
                     wr_left    <= wr_left - CW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_pkt_loader.sv
// Bench for tx_pkt_loader: directed frames plus randomized traffic and FIFO
// backpressure, compared against a frame-level model of the FIFO stream.
module tb_tx_pkt_loader;

   localparam int MAX_B = 1518;
   localparam int MIN_B = 60;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, in_sop, in_eop;
   logic [63:0] in_data;
   logic [7:0]  in_keep;
   logic        txfifo_full = 1'b0;
   logic        txfifo_wr_en;
   logic [63:0] txfifo_din;
   logic [31:0] pkt_cnt;
   logic [15:0] drop_cnt;
   logic        err_oversize;

   logic [63:0] exp_q[$];
   logic [63:0] cap_q[$];
   logic [7:0]  fb [2048];
   int n_chk = 0, n_fail = 0;
   int exp_pkt = 0, exp_drop = 0, exp_err = 0, err_seen = 0, wr_total = 0;
   int full_mode = 0;

   tx_pkt_loader dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_keep      (in_keep),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .txfifo_full  (txfifo_full),
      .txfifo_wr_en (txfifo_wr_en),
      .txfifo_din   (txfifo_din),
      .pkt_cnt      (pkt_cnt),
      .drop_cnt     (drop_cnt),
      .err_oversize (err_oversize)
   );

   // clock and FIFO backpressure
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (full_mode == 1)      txfifo_full = ~txfifo_full;
      else if (full_mode == 2) txfifo_full = ($urandom_range(0, 3) == 0);
      else                     txfifo_full = 1'b0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: every FIFO write is checked against the model stream
   always @(negedge clk) begin
      if (!rst) begin
         if (err_oversize) err_seen++;
         if (txfifo_wr_en) begin
            wr_total++;
            cap_q.push_back(txfifo_din);
            chk("wr_while_full", {63'd0, txfifo_full}, 64'd0);
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", txfifo_din, $time);
            end else begin
               chk("fifo_word", txfifo_din, exp_q.pop_front());
            end
         end
      end
   end

   // frame-level model: what the FIFO must receive for a frame of len bytes in fb
   task automatic model_frame(input int len, input int abort_at);
      int plen;
      logic [63:0] w;
      if (abort_at >= 0) begin
         exp_drop++;
      end else if (len > MAX_B) begin
         exp_drop++;
         exp_err++;
      end else begin
         plen = (len < MIN_B) ? MIN_B : len;
         exp_q.push_back(64'(plen));
         for (int i = 0; i < (plen + 7) / 8; i++) begin
            for (int b = 0; b < 8; b++)
               w[b*8 +: 8] = (i*8 + b < len) ? fb[i*8 + b] : 8'h00;
            exp_q.push_back(w);
         end
         exp_pkt++;
      end
   endtask

   task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e);
      int t;
      in_data = d; in_keep = k; in_sop = s; in_eop = e; in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL in_ready_timeout: got in_ready 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int len, input int abort_at, input bit fixed, input bit gaps);
      int nw, nsend, nb;
      logic [63:0] d;
      logic [7:0] k;
      logic last;
      nw = (len + 7) / 8;
      for (int i = 0; i < len; i++) fb[i] = fixed ? 8'(16 + i) : 8'($urandom_range(0, 255));
      model_frame(len, abort_at);
      nsend = (abort_at >= 0) ? abort_at : nw;
      for (int w = 0; w < nsend; w++) begin
         for (int b = 0; b < 8; b++)
            d[b*8 +: 8] = (w*8 + b < len) ? fb[w*8 + b] : 8'($urandom_range(1, 255));
         last = (w == nw - 1) && (abort_at < 0);
         nb = len - w*8;
         k = last ? 8'((1 << nb) - 1) : 8'($urandom_range(0, 255));
         send_word(d, k, w == 0, last);
         if (gaps && $urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
      chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
      chk({tag, "_err_pulses"}, 64'(err_seen), 64'(exp_err));
   endtask

   initial begin
      int w0, t, len, nw, ab;
      in_valid = 1'b0; in_data = '0; in_keep = '0; in_sop = 1'b0; in_eop = 1'b0;

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_wr_en", {63'd0, txfifo_wr_en}, 64'd0);
      chk("rst_din", txfifo_din, 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_err", {63'd0, err_oversize}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ready_after_rst", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      // 64-byte frame, back-to-back header and data with no backpressure
      cap_q.delete();
      send_frame(64, -1, 0, 0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("hdr_data_latency", {63'd0, txfifo_wr_en}, 64'd1);
      end
      @(negedge clk);
      chk("ready_after_drain", {63'd0, in_ready}, 64'd1);
      wait_drain();
      chk("f64_writes", 64'(cap_q.size()), 64'd9);
      chk("f64_hdr", cap_q[0], 64'h40);
      check_counts("f64");

      // 13-byte runt padded to 60
      cap_q.delete();
      send_frame(13, -1, 1, 0);
      wait_drain();
      chk("f13_writes", 64'(cap_q.size()), 64'd9);
      chk("f13_hdr", cap_q[0], 64'h3C);
      chk("f13_word0", cap_q[1], 64'h1716_1514_1312_1110);
      chk("f13_word1", cap_q[2], 64'h0000_001C_1B1A_1918);
      chk("f13_pad", cap_q[8], 64'h0);
      check_counts("f13");

      // oversize drop then an intact frame
      cap_q.delete();
      send_frame(1519, -1, 0, 0);
      send_frame(64, -1, 0, 0);
      wait_drain();
      chk("ovs_writes", 64'(cap_q.size()), 64'd9);
      check_counts("ovs");

      // FIFO full toggling every cycle
      full_mode = 1;
      w0 = wr_total;
      send_frame(100, -1, 0, 0);
      wait_drain();
      chk("toggle_writes", 64'(wr_total - w0), 64'd14);
      full_mode = 0;
      idle(2);

      // sop on word 3 abandons the unfinished frame
      cap_q.delete();
      send_frame(100, 3, 0, 0);
      send_frame(40, -1, 0, 0);
      wait_drain();
      chk("abort_writes", 64'(cap_q.size()), 64'd9);
      chk("abort_hdr", cap_q[0], 64'h3C);
      check_counts("abort");

      // randomized traffic with random backpressure
      full_mode = 2;
      for (int i = 0; i < 25; i++) begin
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(1480, 1560) : $urandom_range(1, 200);
         nw = (len + 7) / 8;
         ab = -1;
         if (len <= MAX_B && nw > 1 && i < 24 && $urandom_range(0, 9) == 0)
            ab = $urandom_range(1, nw - 1);
         send_frame(len, ab, 0, 1);
         if (ab < 0 && $urandom_range(0, 4) == 0)
            send_word(64'($urandom()), 8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
      end
      wait_drain();
      check_counts("random");
      full_mode = 0;
      idle(2);

      // reset during drain
      w0 = wr_total;
      send_frame(64, -1, 0, 0);
      t = 0;
      while (wr_total < w0 + 5 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("reach_drain_word4", 64'(wr_total - w0 >= 5), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      exp_q.delete();
      exp_pkt = 0; exp_drop = 0; exp_err = 0; err_seen = 0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_wr_en", {63'd0, txfifo_wr_en}, 64'd0);
      chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_ready_after", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      cap_q.delete();
      send_frame(64, -1, 0, 0);
      wait_drain();
      chk("post_rst_writes", 64'(cap_q.size()), 64'd9);
      check_counts("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
